// File: rtl/hand_pose_if.sv
// Pose scheduler bus: frame strobe, both pose sources, the camera valid/ready
// pair and the committed-pose outputs, plus the scheduler's FSM state for debug.
interface hand_pose_if;
    logic        frame_start_in;
    logic        force_btn_in;
    logic [75:0] btn_pose_in;
    logic [75:0] cam_pose_in;
    logic        cam_valid_in;
    logic        cam_ready_out;
    logic [75:0] pose_out;
    logic        pose_valid_out;
    logic        src_sel_out;
    logic        cam_locked_out;
    logic [1:0]  state_dbg;

    modport master (
        output frame_start_in, force_btn_in, btn_pose_in, cam_pose_in, cam_valid_in,
        input  cam_ready_out, pose_out, pose_valid_out, src_sel_out, cam_locked_out, state_dbg
    );

    modport slave (
        input  frame_start_in, force_btn_in, btn_pose_in, cam_pose_in, cam_valid_in,
        output cam_ready_out, pose_out, pose_valid_out, src_sel_out, cam_locked_out, state_dbg
    );
endinterface

// File: rtl/hand_pose_scheduler.sv
// Selects camera or button hand pose and commits it to the renderer only on frame
// boundaries; a watchdog drops back to buttons when the camera stream goes quiet.
module hand_pose_scheduler #(
    parameter int MAX_X       = 3400,
    parameter int MAX_Y       = 3400,
    parameter int MAX_Z       = 500,
    parameter int RESET_XY    = 1800,
    parameter int CAM_TIMEOUT = 3250000,
    parameter int CAM_RELOCK  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    hand_pose_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_BTN = 2'd0,
        ST_ACQ = 2'd1,
        ST_CAM = 2'd2
    } state_t;

    localparam int WD_W = $clog2(CAM_TIMEOUT + 1);
    localparam int LK_W = $clog2(CAM_RELOCK + 1);

    localparam logic [11:0]     X_LIM   = 12'(MAX_X - 1);
    localparam logic [11:0]     Y_LIM   = 12'(MAX_Y - 1);
    localparam logic [13:0]     Z_LIM   = 14'(MAX_Z - 1);
    localparam logic [11:0]     RXY     = 12'(RESET_XY);
    localparam logic [75:0]     RESET_POSE = {RXY, RXY, 14'd0, RXY, RXY, 14'd0};
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(CAM_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(CAM_TIMEOUT - 1);
    localparam logic [LK_W-1:0] LK_TGT  = LK_W'(CAM_RELOCK);

    state_t          state, state_nx;
    logic [LK_W-1:0] lock_cnt, lock_nx;
    logic [WD_W-1:0] wd_cnt;
    logic [75:0]     shadow;
    logic [75:0]     cam_clamped;
    logic [75:0]     pose_r;
    logic            pose_valid_r;
    logic            src_sel_r;
    logic            rst_q;
    logic            accept;
    logic            timeout;

    function automatic logic [75:0] clamp_pose(input logic [75:0] p);
        logic [11:0] xb, yb, xt, yt;
        logic [13:0] zb, zt;
        xb = (p[75:64] > X_LIM) ? X_LIM : p[75:64];
        yb = (p[63:52] > Y_LIM) ? Y_LIM : p[63:52];
        zb = (p[51:38] > Z_LIM) ? Z_LIM : p[51:38];
        xt = (p[37:26] > X_LIM) ? X_LIM : p[37:26];
        yt = (p[25:14] > Y_LIM) ? Y_LIM : p[25:14];
        zt = (p[13:0]  > Z_LIM) ? Z_LIM : p[13:0];
        return {xb, yb, zb, xt, yt, zt};
    endfunction

    // Handshake: a camera sample transfers on a cycle where cam_valid_in and
    // cam_ready_out are both high. Ready drops in the cycle after reset and on
    // every frame_start_in, so the shadow never changes while it is being committed.
    assign bus.cam_ready_out = !rst_q && !bus.frame_start_in;
    assign accept            = bus.cam_valid_in && bus.cam_ready_out;
    assign timeout           = (wd_cnt == WD_LAST) && !accept;
    assign cam_clamped       = clamp_pose(bus.cam_pose_in);

    assign bus.pose_out       = pose_r;
    assign bus.pose_valid_out = pose_valid_r;
    assign bus.src_sel_out    = src_sel_r;
    assign bus.cam_locked_out = (state == ST_CAM);
    assign bus.state_dbg      = state;

    always_ff @(posedge clk_in) begin
        rst_q <= rst_in;
        if (rst_in) begin
            state        <= ST_BTN;
            lock_cnt     <= '0;
            wd_cnt       <= '0;
            shadow       <= RESET_POSE;
            pose_r       <= RESET_POSE;
            pose_valid_r <= 1'b0;
            src_sel_r    <= 1'b0;
        end else begin
            state    <= state_nx;
            lock_cnt <= lock_nx;
            if (accept) begin
                wd_cnt <= '0;
                shadow <= cam_clamped;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            pose_valid_r <= bus.frame_start_in;
            // Source is decided by the state held during the frame_start cycle.
            if (bus.frame_start_in) begin
                pose_r    <= (state == ST_CAM) ? shadow : bus.btn_pose_in;
                src_sel_r <= (state == ST_CAM);
            end
        end
    end

    always_comb begin
        state_nx = state;
        lock_nx  = lock_cnt;
        if (bus.force_btn_in) begin
            state_nx = ST_BTN;
            lock_nx  = '0;
        end else begin
            case (state)
                ST_BTN: begin
                    if (accept) begin
                        lock_nx  = LK_W'(1);
                        state_nx = (CAM_RELOCK == 1) ? ST_CAM : ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (accept) begin
                        lock_nx = lock_cnt + LK_W'(1);
                        if ((lock_cnt + LK_W'(1)) == LK_TGT) state_nx = ST_CAM;
                    end else if (timeout) begin
                        state_nx = ST_BTN;
                        lock_nx  = '0;
                    end
                end
                ST_CAM: begin
                    if (timeout) begin
                        state_nx = ST_BTN;
                        lock_nx  = '0;
                    end
                end
                default: begin
                    state_nx = ST_BTN;
                    lock_nx  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hand_pose_scheduler.sv
// Bench for hand_pose_scheduler: directed scenarios then random traffic, checked
// against a cycle-level model of lock, watchdog and frame-commit rules.
module tb_hand_pose_scheduler;

    localparam int MAX_X   = 3400;
    localparam int MAX_Y   = 3400;
    localparam int MAX_Z   = 500;
    localparam int TIMEOUT = 100;
    localparam int RELOCK  = 4;

    logic clk_in;
    logic rst_in;
    hand_pose_if bus();

    hand_pose_scheduler #(.CAM_TIMEOUT(TIMEOUT), .CAM_RELOCK(RELOCK)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    logic [76:0] exp_q[$];

    // Reference model state
    bit          m_known  = 0;
    bit          m_rst_q  = 1;
    bit          m_locked = 0;
    int          m_streak = 0;
    int          m_idle   = 0;
    logic [75:0] m_shadow;
    logic [75:0] m_pose;

    function automatic logic [75:0] make_pose(input int xb, input int yb, input int zb,
                                              input int xt, input int yt, input int zt);
        return {12'(xb), 12'(yb), 14'(zb), 12'(xt), 12'(yt), 14'(zt)};
    endfunction

    function automatic logic [75:0] reset_pose();
        return make_pose(1800, 1800, 0, 1800, 1800, 0);
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [75:0] model_clamp(input logic [75:0] p);
        return make_pose(min_int(int'(p[75:64]), MAX_X - 1), min_int(int'(p[63:52]), MAX_Y - 1),
                         min_int(int'(p[51:38]), MAX_Z - 1), min_int(int'(p[37:26]), MAX_X - 1),
                         min_int(int'(p[25:14]), MAX_Y - 1), min_int(int'(p[13:0]),  MAX_Z - 1));
    endfunction

    function automatic logic [75:0] rand_pose();
        logic [95:0] t;
        if ($urandom_range(0, 1) == 0) begin
            t = {$urandom(), $urandom(), $urandom()};
            return t[75:0];
        end
        return make_pose($urandom_range(0, 3399), $urandom_range(0, 3399), $urandom_range(0, 499),
                         $urandom_range(0, 3399), $urandom_range(0, 3399), $urandom_range(0, 499));
    endfunction

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare level outputs, advance the model, cross the edge.
    task automatic tick();
        logic        acc;
        logic [75:0] p;
        #1;
        if (m_known) begin
            chk("cam_ready", 76'(bus.cam_ready_out), 76'(!m_rst_q && !bus.frame_start_in));
            chk("cam_locked", 76'(bus.cam_locked_out), 76'(m_locked));
            chk("pose_hold", bus.pose_out, m_pose);
        end
        if (rst_in) begin
            m_known  = 1;
            m_rst_q  = 1;
            m_locked = 0;
            m_streak = 0;
            m_idle   = 0;
            m_shadow = reset_pose();
            m_pose   = reset_pose();
        end else begin
            acc = bus.cam_valid_in && !m_rst_q && !bus.frame_start_in;
            if (bus.frame_start_in) begin
                p = m_locked ? m_shadow : bus.btn_pose_in;
                exp_q.push_back({m_locked, p});
                m_pose = p;
            end
            if (acc) begin
                m_shadow = model_clamp(bus.cam_pose_in);
                m_idle   = 0;
            end else begin
                m_idle++;
            end
            if (bus.force_btn_in) begin
                m_locked = 0;
                m_streak = 0;
            end else if (acc) begin
                if (!m_locked) begin
                    m_streak++;
                    if (m_streak >= RELOCK) m_locked = 1;
                end
            end else if (m_idle == TIMEOUT) begin
                m_locked = 0;
                m_streak = 0;
            end
            m_rst_q = 0;
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Monitor: every pose_valid_out pulse must match the oldest expected commit.
    always @(negedge clk_in) begin
        logic [76:0] e;
        if (m_known && (bus.pose_valid_out === 1'b1 || exp_q.size() > 0)) begin
            if (exp_q.size() == 0) begin
                chk("pose_valid_extra", 76'(bus.pose_valid_out), 76'(0));
            end else begin
                e = exp_q.pop_front();
                chk("pose_valid", 76'(bus.pose_valid_out), 76'(1));
                chk("commit_pose", bus.pose_out, e[75:0]);
                chk("commit_src", 76'(bus.src_sel_out), 76'(e[76]));
            end
        end
    end

    task automatic idle(input int n);
        bus.cam_valid_in   = 1'b0;
        bus.frame_start_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_cam(input logic [75:0] p);
        bus.cam_pose_in  = p;
        bus.cam_valid_in = 1'b1;
        tick();
        bus.cam_valid_in = 1'b0;
    endtask

    task automatic frame();
        bus.frame_start_in = 1'b1;
        tick();
        bus.frame_start_in = 1'b0;
    endtask

    logic [75:0] pose_a, pose_b;
    int          density;

    initial begin
        rst_in             = 1'b1;
        bus.frame_start_in = 1'b0;
        bus.force_btn_in   = 1'b0;
        bus.btn_pose_in    = reset_pose();
        bus.cam_pose_in    = '0;
        bus.cam_valid_in   = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        chk("t1_pose", bus.pose_out, reset_pose());
        chk("t1_src", 76'(bus.src_sel_out), 76'(0));
        chk("t1_ready", 76'(bus.cam_ready_out), 76'(0));
        chk("t1_valid", 76'(bus.pose_valid_out), 76'(0));
        rst_in = 1'b0;

        // Button path
        bus.btn_pose_in = make_pose(1816, 1800, 0, 1800, 1800, 0);
        frame();
        chk("t2_xbot", 76'(bus.pose_out[75:64]), 76'(1816));
        chk("t2_src", 76'(bus.src_sel_out), 76'(0));
        tick();
        chk("t2_valid_once", 76'(bus.pose_valid_out), 76'(0));

        // Relock with clamping
        pose_a = make_pose(4000, 100, 20, 50, 60, 600);
        for (int i = 0; i < 4; i++) begin
            send_cam(pose_a);
            if (i == 3) chk("t3_locked", 76'(bus.cam_locked_out), 76'(1));
            else        chk("t3_not_locked", 76'(bus.cam_locked_out), 76'(0));
            idle(9);
        end
        frame();
        chk("t3_xbot", 76'(bus.pose_out[75:64]), 76'(3399));
        chk("t3_ztop", 76'(bus.pose_out[13:0]), 76'(499));
        chk("t3_src", 76'(bus.src_sel_out), 76'(1));

        // Watchdog timeout
        send_cam(pose_a);
        idle(TIMEOUT - 1);
        chk("t4_still_locked", 76'(bus.cam_locked_out), 76'(1));
        idle(1);
        chk("t4_unlocked", 76'(bus.cam_locked_out), 76'(0));
        frame();
        chk("t4_src", 76'(bus.src_sel_out), 76'(0));

        // Camera sample colliding with frame_start
        pose_a = make_pose(100, 200, 30, 400, 500, 60);
        pose_b = make_pose(3500, 700, 5000, 800, 900, 70);
        repeat (4) send_cam(pose_a);
        bus.cam_pose_in    = pose_b;
        bus.cam_valid_in   = 1'b1;
        bus.frame_start_in = 1'b1;
        #1;
        chk("t5_ready_low", 76'(bus.cam_ready_out), 76'(0));
        tick();
        bus.frame_start_in = 1'b0;
        chk("t5_old_shadow", bus.pose_out, pose_a);
        tick();
        bus.cam_valid_in = 1'b0;
        frame();
        chk("t5_new_shadow", bus.pose_out, make_pose(3399, 700, 499, 800, 900, 70));

        // Force override, then reset part-way through relock
        bus.force_btn_in = 1'b1;
        tick();
        bus.force_btn_in = 1'b0;
        chk("t6_forced", 76'(bus.cam_locked_out), 76'(0));
        repeat (2) send_cam(pose_a);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        idle(1);
        repeat (3) send_cam(pose_b);
        chk("t6_three_not_enough", 76'(bus.cam_locked_out), 76'(0));
        send_cam(pose_b);
        chk("t6_relocked", 76'(bus.cam_locked_out), 76'(1));

        // Random traffic in blocks of varying camera density
        for (int blk = 0; blk < 20; blk++) begin
            case ($urandom_range(0, 3))
                0:       density = 0;
                1:       density = 5;
                2:       density = 40;
                default: density = 90;
            endcase
            for (int c = 0; c < 200; c++) begin
                bus.frame_start_in = ($urandom_range(0, 15) == 0);
                bus.cam_valid_in   = ($urandom_range(0, 99) < density);
                bus.cam_pose_in    = rand_pose();
                bus.force_btn_in   = ($urandom_range(0, 79) == 0);
                rst_in             = ($urandom_range(0, 599) == 0);
                bus.btn_pose_in    = make_pose($urandom_range(0, 3399), $urandom_range(0, 3399),
                                               $urandom_range(0, 499), $urandom_range(0, 3399),
                                               $urandom_range(0, 3399), $urandom_range(0, 499));
                tick();
            end
        end
        rst_in           = 1'b0;
        bus.force_btn_in = 1'b0;
        idle(3);
        chk("queue_drained", 76'(exp_q.size()), 76'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
